// File: rtl/alu_chain_pkg.sv
// Shared definitions for the wide-add sequencer that drives the 8-bit ALU.
// Optional subtract support is enabled with macro ALU_CHAIN_SEQ_SUB_EN.
package alu_chain_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chain_state_e;

  // Width of the byte index counter; never narrower than one bit.
  function automatic int idx_w(input int nbytes);
    return (nbytes <= 2) ? 1 : $clog2(nbytes);
  endfunction

endpackage

// File: rtl/alu_8bit.sv
// Existing shared 8-bit ALU (add path): out/cout are combinational.
module alu_8bit (
  input  logic [7:0] reg1,
  input  logic [7:0] reg2,
  input  logic       cin,
  output logic [7:0] out,
  output logic       cout
);

  // 9-bit sum splits into carry out and byte result.
  always_comb begin
    {cout, out} = 9'(reg1) + 9'(reg2) + 9'(cin);
  end

endmodule

// File: rtl/alu_chain_seq.sv
// Multi-cycle wide adder: feeds one byte per cycle to an external alu_8bit,
// chaining carry between bytes. Macro ALU_CHAIN_SEQ_SUB_EN adds op_sub (A-B).
module alu_chain_seq
  import alu_chain_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [8*NBYTES-1:0]    op_a,
  input  logic [8*NBYTES-1:0]    op_b,
  input  logic                   op_cin,
`ifdef ALU_CHAIN_SEQ_SUB_EN
  input  logic                   op_sub,
`endif
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [8*NBYTES-1:0]    sum,
  output logic                   cout,
  output logic                   ovf,
  output logic [7:0]             alu_reg1,
  output logic [7:0]             alu_reg2,
  output logic                   alu_cin,
  input  logic [7:0]             alu_out,
  input  logic                   alu_cout
);

  localparam int W     = BYTE_W * NBYTES;
  localparam int IDX_W = idx_w(NBYTES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NBYTES - 1);

  chain_state_e     state_q, state_d;
  logic [IDX_W-1:0] idx_q;
  logic             carry_q;
  logic [W-1:0]     a_q, b_q;
  logic [W-1:0]     sum_q;
  logic             cout_q, ovf_q;
  logic             accept, last_byte;
  logic [W-1:0]     b_in;
  logic             cin_in;

  // Selects byte i of a wide vector.
  function automatic logic [BYTE_W-1:0] byte_sel(input logic [W-1:0] v,
                                                 input logic [IDX_W-1:0] i);
    return v[BYTE_W*int'(i) +: BYTE_W];
  endfunction

  assign accept    = in_valid && in_ready;
  assign last_byte = (idx_q == LAST_IDX);

  // Operand conditioning at acceptance (subtract inverts B and forces cin=1).
  always_comb begin
    b_in   = op_b;
    cin_in = op_cin;
`ifdef ALU_CHAIN_SEQ_SUB_EN
    if (op_sub) begin
      b_in   = ~op_b;
      cin_in = 1'b1;
    end
`endif
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and handshake / ALU-drive outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    alu_reg1  = '0;
    alu_reg2  = '0;
    alu_cin   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) state_d = ST_RUN;
      end
      ST_RUN: begin
        alu_reg1 = byte_sel(a_q, idx_q);
        alu_reg2 = byte_sel(b_q, idx_q);
        alu_cin  = carry_q;
        if (last_byte) state_d = ST_DONE;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Operand latches: data only, loaded on acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_q <= op_a;
      b_q <= b_in;
    end
  end

  // Byte-serial accumulation: capture ALU byte, chain carry, finish on last byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q   <= '0;
      carry_q <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            idx_q   <= '0;
            carry_q <= cin_in;
          end
        end
        ST_RUN: begin
          sum_q[BYTE_W*int'(idx_q) +: BYTE_W] <= alu_out;
          carry_q <= alu_cout;
          if (last_byte) begin
            idx_q  <= '0;
            cout_q <= alu_cout;
            // b_q already holds the inverted B when subtracting.
            ovf_q  <= (a_q[W-1] == b_q[W-1]) && (alu_out[7] != a_q[W-1]);
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;

endmodule
